// File: rtl/onehot_pkg.sv
// Shared one-hot helpers: demux state encoding and a width-agnostic one-hot test.
package onehot_pkg;

  typedef enum logic {EMPTY, FULL} demux_state_t;

  localparam int ONEHOT_MAX_W = 64;
  typedef logic [ONEHOT_MAX_W-1:0] onehot_vec_t;

  // Callers zero-extend into onehot_vec_t; bits at or above w are ignored.
  function automatic logic is_onehot(input onehot_vec_t v, input int w);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < ONEHOT_MAX_W; i++) begin
      if (i < w && v[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

endpackage

// File: rtl/onehot_demux.sv
// Registered one-hot stream demultiplexer: one input stream fanned out to N
// outputs through a single holding register; non-one-hot selects are dropped.
module onehot_demux
  import onehot_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_sel,
  input  logic [DW-1:0]   i_data,
  input  logic            i_valid,
  output logic            i_ready,
  output logic [N*DW-1:0] o,
  output logic [N-1:0]    o_valid,
  input  logic [N-1:0]    o_ready,
  output logic            err
);

  demux_state_t  r_state;
  logic [N-1:0]  r_sel;
  logic [DW-1:0] r_data;
  logic          r_err;

  logic w_full;
  logic w_drain;
  logic w_accept;
  logic w_legal;

  assign w_full   = (r_state == FULL);
  assign w_drain  = w_full && |(r_sel & o_ready);
  assign i_ready  = !rst && (!w_full || w_drain);
  assign w_accept = i_valid && i_ready;
  assign w_legal  = is_onehot(onehot_vec_t'(i_sel), N);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_sel   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept && w_legal) begin
        r_sel   <= i_sel;
        r_data  <= i_data;
        r_state <= FULL;
      end else begin
        // An illegal beat is swallowed; the held beat may still drain alongside it.
        if (w_accept) r_err <= 1'b1;
        if (w_drain)  r_state <= EMPTY;
      end
    end
  end

  assign o_valid = w_full ? r_sel : '0;
  assign err     = r_err;

  for (genvar j = 0; j < N; j++) begin : g_out
    assign o[(j+1)*DW-1 -: DW] = {DW{r_sel[j]}} & r_data;
  end

endmodule

// File: doc/onehot_demux.md
# onehot_demux

Registered one-hot stream demultiplexer. Routes a single valid/ready input stream to one of `N` output streams selected by a one-hot `sel` vector that travels with each beat. It is the fan-out counterpart of the one-hot mux in the muxes library. A one-entry output register breaks the datapath, and beats whose select is not strictly one-hot are dropped and flagged.

## Interface
- `DW`, default 8: data width per beat.
- `N`, default 4: number of output streams; must be ≥ 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_sel`  in  N  one-hot destination for the current input beat.
- `i_data`  in  DW  input payload.
- `i_valid`  in  1  input beat present.
- `i_ready`  out  1  block accepts the input beat this cycle.
- `o`  out  N*DW  output payloads; slice j is `o[(j+1)*DW-1 -: DW]`.
- `o_valid`  out  N  per-output valid.
- `o_ready`  in  N  per-output ready.
- `err`  out  1  one-cycle pulse: the dropped beat had a non-one-hot select.

## Operation
- State: `EMPTY` or `FULL`. Holding registers `sel_q[N-1:0]` and `data_q[DW-1:0]`.
- Handshake: a transfer occurs when `valid && ready` on the same cycle. Once `valid` is raised, the source must not drop it or change `sel`/`data` until the transfer.
- `drain` = `FULL && |(sel_q & o_ready)`.
- `i_ready` = `!FULL || drain`. This is a combinational path from `o_ready`, which is permitted.
- `o_valid` = `FULL ? sel_q : '0`.
- Slice j of `o` = `data_q` when `sel_q[j]` is 1, otherwise zero. Unselected slices are always zero.
- Input beat accepted with a legal select (exactly one bit set):
  - `sel_q <= i_sel`, `data_q <= i_data`.
  - Next state is `FULL`.
- Input beat accepted with an illegal select (zero bits set, or more than one):
  - The beat is consumed and discarded; `sel_q` and `data_q` are not loaded.
  - `err <= 1` for exactly one cycle.
  - The state becomes `EMPTY` if `drain` is true this cycle, otherwise it is unchanged.
- No input accepted and `drain` true: next state is `EMPTY`. `data_q` keeps its value, which is don't-care.
- Accept and `drain` in the same cycle: the new legal beat replaces the old one and the state stays `FULL`. This sustains one beat per cycle.
- Accept with an illegal select while `FULL` and not draining: impossible, because `i_ready` is 0.
- The legality check is a popcount == 1 test, not `sel != 0`.
- `err` is otherwise 0.

## Timing
- Latency: a beat accepted on edge k appears on `o_valid`/`o` during cycle k+1.
- Throughput: 1 beat per cycle while the selected consumer keeps `o_ready` high.
- Stall: while `o_valid[j] && !o_ready[j]`, `o`, `o_valid` and `sel_q` hold stable and `i_ready` = 0.
- `o_ready` bits of unselected outputs have no effect.
- `err` is asserted in the cycle after the offending transfer.
- Reset values: state `EMPTY`, `sel_q = 0`, `data_q = 0`, `err = 0`.
  - Outputs during and after reset: `o_valid = 0`, `o = 0`, `i_ready = 1` in the first cycle after `rst` deasserts.
- `i_ready` is held 0 while `rst` = 1.
- Reset mid-operation: a held beat is discarded without being delivered, and no `err` is raised.

## Structure
- Package `onehot_pkg`:
  - `typedef enum logic {EMPTY, FULL} demux_state_t`.
  - Function `is_onehot(logic [N-1:0])`, parameterised through a width argument or a generate-friendly loop. It is shared with future one-hot arbiters and encoders.
- No sub-module. The output gating is the inline expression `{DW{sel_q[j]}} & data_q` inside a generate loop.

## Test plan
- Reset, then `i_valid` with `i_sel=4'b0100`, `i_data=8'hA5` → next cycle `o_valid=4'b0100`, `o[23:16]=8'hA5`, all other slices `8'h00`, `err=0`.
- Back-to-back beats to outputs 0,1,2,3 with `o_ready=4'b1111` → one delivery per cycle in order, `i_ready` constantly 1.
- Hold `o_ready[2]=0` with a beat in flight to output 2 → `i_ready=0`, `o` stable for 5 cycles. Release → delivered, and the next beat is accepted that same cycle.
- Illegal selects `i_sel=4'b0000` and `4'b0110` → each is consumed, `o_valid` stays 0, `err` pulses once per beat.
- Assert `rst` while `FULL` and stalled → next cycle `o_valid=0`, `o=0`, `err=0`, `i_ready=1` after release.
- Random legal/illegal traffic with random `o_ready` → scoreboard: every legal beat is delivered exactly once to its selected port, and `err` count equals the number of illegal beats.
